// File: rtl/laplacian_stream_3x3_if.sv
// Pixel-in / result-out stream bundle for laplacian_stream_3x3.
// slave is the filter's view, master is the pixel source / result sink's view.
interface laplacian_stream_3x3_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] in_pix;
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic             mode;
    logic [PIX_W-1:0] out_pix;
    logic             out_valid;
    logic             out_eol;
    logic             out_eof;
    logic             out_ready;

    modport slave (
        input  in_pix,
        input  in_valid,
        input  in_sof,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_pix,
        output out_valid,
        output out_eol,
        output out_eof
    );

    modport master (
        output in_pix,
        output in_valid,
        output in_sof,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_pix,
        input  out_valid,
        input  out_eol,
        input  out_eof
    );
endinterface

// File: rtl/laplacian_stream_3x3.sv
// Streaming 3x3 Laplacian (4- or 8-neighbour) over a raster pixel stream with two line buffers.
// Three stages: window/line-buffer update, signed kernel sum, clamp to output; whole pipe stalls together.
module laplacian_stream_3x3 #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    laplacian_stream_3x3_if.slave bus
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;
    localparam int SW = PIX_W + 3;
    localparam int DW = PIX_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // position counters and per-frame mode
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          mode_q, mode_d;

    // line buffers: lb0 = previous line, lb1 = two lines back (not reset)
    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];

    // window [row][col]: row 0 oldest line, col 2 newest column
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];

    logic s1_valid_q, s1_valid_d;
    logic s1_eol_q, s1_eol_d;
    logic s1_eof_q, s1_eof_d;
    logic s1_mode_q, s1_mode_d;

    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_eol_q, s2_eol_d;
    logic                 s2_eof_q, s2_eof_d;
    logic signed [DW-1:0] s2_diff_q, s2_diff_d;

    logic [PIX_W-1:0] out_pix_q, out_pix_d;
    logic             out_valid_q, out_valid_d;
    logic             out_eol_q, out_eol_d;
    logic             out_eof_q, out_eof_d;

    logic                 stall;
    logic                 accept;
    logic [CW-1:0]        cur_col;
    logic [RW-1:0]        cur_row;
    logic                 cur_mode;
    logic [PIX_W-1:0]     lb0_rd;
    logic [PIX_W-1:0]     lb1_rd;
    logic [SW-1:0]        nsum4;
    logic [SW-1:0]        ncorner;
    logic [SW-1:0]        nsum;
    logic [SW-1:0]        cscaled;
    logic signed [DW-1:0] diff;
    logic [PIX_W-1:0]     clamp;

    assign stall  = out_valid_q && !bus.out_ready;
    assign accept = bus.in_valid && !stall;

    assign bus.in_ready  = !stall;
    assign bus.out_pix   = out_pix_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_eof   = out_eof_q;

    // an SOF pixel sits at (0,0) and carries the freshly sampled mode
    always_comb begin
        cur_col  = bus.in_sof ? '0 : col_q;
        cur_row  = bus.in_sof ? '0 : row_q;
        cur_mode = bus.in_sof ? bus.mode : mode_q;
        lb0_rd   = lb0_q[cur_col];
        lb1_rd   = lb1_q[cur_col];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[cur_col] <= lb0_q[cur_col];
            lb0_q[cur_col] <= bus.in_pix;
        end
    end

    // kernel arithmetic on the window captured by stage 1
    always_comb begin
        nsum4   = SW'(win_q[0][1]) + SW'(win_q[2][1]) + SW'(win_q[1][0]) + SW'(win_q[1][2]);
        ncorner = SW'(win_q[0][0]) + SW'(win_q[0][2]) + SW'(win_q[2][0]) + SW'(win_q[2][2]);
        nsum    = s1_mode_q ? (nsum4 + ncorner) : nsum4;
        cscaled = s1_mode_q ? {win_q[1][1], 3'b000} : {1'b0, win_q[1][1], 2'b00};
        diff    = $signed({1'b0, cscaled}) - $signed({1'b0, nsum});
    end

    always_comb begin
        if (s2_diff_q[DW-1]) begin
            clamp = '0;
        end else if (|s2_diff_q[DW-2:PIX_W]) begin
            clamp = '1;
        end else begin
            clamp = s2_diff_q[PIX_W-1:0];
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        win_d       = win_q;
        s1_valid_d  = s1_valid_q;
        s1_eol_d    = s1_eol_q;
        s1_eof_d    = s1_eof_q;
        s1_mode_d   = s1_mode_q;
        s2_valid_d  = s2_valid_q;
        s2_eol_d    = s2_eol_q;
        s2_eof_d    = s2_eof_q;
        s2_diff_d   = s2_diff_q;
        out_pix_d   = out_pix_q;
        out_valid_d = out_valid_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;

        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            if (bus.in_sof) begin
                mode_d = bus.mode;
            end
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = bus.in_pix;
        end

        if (!stall) begin
            s1_valid_d  = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
            s1_eol_d    = cur_col == COL_LAST;
            s1_eof_d    = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
            s1_mode_d   = cur_mode;
            s2_valid_d  = s1_valid_q;
            s2_eol_d    = s1_eol_q;
            s2_eof_d    = s1_eof_q;
            s2_diff_d   = diff;
            out_valid_d = s2_valid_q;
            out_pix_d   = clamp;
            out_eol_d   = s2_eol_q;
            out_eof_d   = s2_eof_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
            s1_valid_q  <= 1'b0;
            s1_eol_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            s1_mode_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_eol_q    <= 1'b0;
            s2_eof_q    <= 1'b0;
            s2_diff_q   <= '0;
            out_pix_q   <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            win_q       <= win_d;
            s1_valid_q  <= s1_valid_d;
            s1_eol_q    <= s1_eol_d;
            s1_eof_q    <= s1_eof_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            s2_eol_q    <= s2_eol_d;
            s2_eof_q    <= s2_eof_d;
            s2_diff_q   <= s2_diff_d;
            out_pix_q   <= out_pix_d;
            out_valid_q <= out_valid_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
        end
    end
endmodule

// File: tb/tb_laplacian_stream_3x3.sv
// Directed bench for laplacian_stream_3x3 on a 5x4 image: uniform, impulse, mixed frames,
// mode latching, bubbles, backpressure, mid-frame reset and mid-frame SOF.
module tb_laplacian_stream_3x3;
    localparam int PIX_W = 8;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    laplacian_stream_3x3_if #(.PIX_W(PIX_W)) bus ();

    laplacian_stream_3x3 #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // mixed frame; hand-computed results: mode0 -> (1,1)=56,(2,2)=89, mode1 -> 94,154, rest 0
    logic [7:0] mix [NPIX] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5,
                               8'd6, 8'd20, 8'd7, 8'd5, 8'd9,
                               8'd8, 8'd9, 8'd30, 8'd11, 8'd12,
                               8'd13, 8'd14, 8'd4, 8'd16, 8'd17};

    logic [7:0] got_pix [NOUT+4];
    logic       got_eol [NOUT+4];
    logic       got_eof [NOUT+4];
    int n_out;
    int acc_iter;
    int first_out_iter;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int fr, input int i);
        case (fr)
            0:       return 8'd100;
            1:       return (i == 12) ? 8'd10 : 8'd0;
            2:       return (i == 12) ? 8'd255 : 8'd0;
            3:       return mix[i];
            default: return 8'd200;
        endcase
    endfunction

    task automatic run(input string tag, input int fr, input int npix, input logic md,
                       input int toggle_at, input int gap, input bit hold_low,
                       input bit stall_once, input bit drain);
        int sent = 0;
        int post = 0;
        int iter = 0;
        bit stalled = 0;
        logic [7:0] snap_pix;
        logic snap_eol, snap_eof;
        n_out = 0;
        acc_iter = -1;
        first_out_iter = -1;
        while (iter < BUDGET) begin
            @(negedge clk);
            if (sent < npix && (gap == 0 || (iter % 2) == 0)) begin
                bus.in_valid = 1'b1;
                bus.in_pix   = pix_of(fr, sent);
                bus.in_sof   = (sent == 0);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_sof   = 1'b0;
            end
            bus.mode = (toggle_at >= 0 && sent >= toggle_at) ? ~md : md;
            bus.out_ready = !hold_low;
            #1;
            if (first_out_iter < 0 && bus.out_valid) first_out_iter = iter;
            if (stall_once && !stalled && bus.out_valid) begin
                stalled = 1;
                snap_pix = bus.out_pix;
                snap_eol = bus.out_eol;
                snap_eof = bus.out_eof;
                bus.out_ready = 1'b0;
                #1;
                check_val({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk);
                    iter++;
                    #1;
                    check_val({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                    check_val({tag, "_hold_pix"}, 32'(bus.out_pix), 32'(snap_pix));
                    check_val({tag, "_hold_eol"}, 32'(bus.out_eol), 32'(snap_eol));
                    check_val({tag, "_hold_eof"}, 32'(bus.out_eof), 32'(snap_eof));
                    check_val({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
                end
                continue;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (n_out < NOUT + 4) begin
                    got_pix[n_out] = bus.out_pix;
                    got_eol[n_out] = bus.out_eol;
                    got_eof[n_out] = bus.out_eof;
                end
                $display("%s out %0d pix=%0d eol=%0b eof=%0b", tag, n_out, bus.out_pix,
                         bus.out_eol, bus.out_eof);
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (sent == 2 * IMG_W + 2) acc_iter = iter;
                sent++;
            end
            @(posedge clk);
            iter++;
            if (sent >= npix) post++;
            if (post >= (drain ? 8 : 1)) break;
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        check_val({tag, "_sent"}, 32'(sent), 32'(npix));
    endtask

    // every output is 0 except centres (1,1) (index 0) and (2,2) (index 4)
    task automatic check_frame(input string tag, input int e0, input int e4);
        int exp;
        check_val({tag, "_count"}, 32'(n_out), 32'(NOUT));
        for (int i = 0; i < NOUT && i < n_out; i++) begin
            exp = (i == 0) ? e0 : (i == 4) ? e4 : 0;
            check_val($sformatf("%s_pix%0d", tag, i), 32'(got_pix[i]), 32'(exp));
            check_val($sformatf("%s_eol%0d", tag, i), 32'(got_eol[i]), 32'((i == 2) || (i == 5)));
            check_val($sformatf("%s_eof%0d", tag, i), 32'(got_eof[i]), 32'(i == 5));
        end
    endtask

    initial begin
        bus.in_pix    = '0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_pix", 32'(bus.out_pix), 32'd0);
        check_val("rst_out_eol", 32'(bus.out_eol), 32'd0);
        check_val("rst_out_eof", 32'(bus.out_eof), 32'd0);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run("uni_m1", 0, NPIX, 1'b1, -1, 0, 0, 0, 1);
        check_frame("uni_m1", 0, 0);
        check_val("latency", 32'(first_out_iter - 1 - acc_iter), 32'd2);
        run("uni_m0", 0, NPIX, 1'b0, -1, 0, 0, 0, 1);
        check_frame("uni_m0", 0, 0);

        run("imp10_m1", 1, NPIX, 1'b1, -1, 0, 0, 0, 1);
        check_frame("imp10_m1", 0, 80);
        run("imp10_m0", 1, NPIX, 1'b0, -1, 0, 0, 0, 1);
        check_frame("imp10_m0", 0, 40);
        run("imp255_m1", 2, NPIX, 1'b1, -1, 0, 0, 0, 1);
        check_frame("imp255_m1", 0, 255);
        run("imp255_m0", 2, NPIX, 1'b0, -1, 0, 0, 0, 1);
        check_frame("imp255_m0", 0, 255);

        run("mix_m0", 3, NPIX, 1'b0, -1, 0, 0, 0, 1);
        check_frame("mix_m0", 56, 89);
        run("mix_m1", 3, NPIX, 1'b1, -1, 0, 0, 0, 1);
        check_frame("mix_m1", 94, 154);

        run("toggle", 3, NPIX, 1'b0, 7, 0, 0, 0, 1);
        check_frame("toggle", 56, 89);
        run("after_toggle", 3, NPIX, 1'b1, -1, 0, 0, 0, 1);
        check_frame("after_toggle", 94, 154);

        run("bubbles", 3, NPIX, 1'b1, -1, 1, 0, 0, 1);
        check_frame("bubbles", 94, 154);

        run("stall", 3, NPIX, 1'b1, -1, 0, 0, 1, 1);
        check_frame("stall", 94, 154);

        // partial frame held at the output, then asynchronous reset
        run("pre_rst", 3, 13, 1'b1, -1, 0, 1, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        check_val("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check_val("pre_rst_pix", 32'(bus.out_pix), 32'd94);
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("midrst_out_pix", 32'(bus.out_pix), 32'd0);
        check_val("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", 3, NPIX, 1'b1, -1, 0, 0, 0, 1);
        check_frame("post_rst", 94, 154);

        // 8 pixels of a frame, then SOF on the 9th pixel restarts the counters
        run("partial", 4, 8, 1'b1, -1, 0, 0, 0, 0);
        run("resof", 3, NPIX, 1'b0, -1, 0, 0, 0, 1);
        check_frame("resof", 56, 89);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/laplacian_stream_3x3.md
# laplacian_stream_3x3

Streaming 3x3 Laplacian edge filter with a configurable pixel width and image size, and a runtime choice between the 4-neighbour and 8-neighbour kernels. It accepts one raster-order pixel per cycle over a valid/ready handshake. It buffers two previous lines internally and emits one saturated, unsigned result per interior pixel. It is the streaming, clocked successor to the combinational single-window Laplacian blocks and sits between the pixel source and the downstream threshold/accumulate stages of the convolution datapath.

## Interface
Parameters:
- PIX_W, 8, input and output pixel width (unsigned)
- IMG_W, 640, pixels per line (>= 3)
- IMG_H, 480, lines per frame (>= 3)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; all state clears on assertion, release is synchronous to clk
- in_pix  input  PIX_W  input pixel, raster order
- in_valid  input  1  in_pix valid
- in_sof  input  1  marks the first pixel of a frame; qualified by in_valid
- in_ready  output  1  block can accept a pixel
- mode  input  1  0 = 4-neighbour kernel (4c - N - S - E - W), 1 = 8-neighbour kernel (8c - sum of 8 neighbours)
- out_pix  output  PIX_W  filtered pixel, clamped to [0, 2^PIX_W-1]
- out_valid  output  1  out_pix valid
- out_eol  output  1  last output of an output row; qualified by out_valid
- out_eof  output  1  last output of the frame; qualified by out_valid
- out_ready  input  1  downstream accepts the output

## Operation
- Accept: an input is accepted on an edge where in_valid && in_ready. Each accepted pixel has a position (row r, col c) held in counters.
- Counters: in_sof on an accepted pixel forces that pixel to position (0,0). Otherwise the position advances col-first. c wraps at IMG_W-1 with r+1, and (IMG_W-1, IMG_H-1) wraps to (0,0).
- in_sof arriving mid-frame restarts the counters. Outputs already in the pipeline still drain.
- Mode: mode is sampled into a mode register only when an in_sof pixel is accepted. It is constant for the whole frame, and changes between SOFs are ignored.
- Line buffers: there are two IMG_W-deep buffers, LB0 (previous line) and LB1 (two lines back). On accept at column c: read LB1[c] and LB0[c], write LB1[c] <= LB0[c] and LB0[c] <= in_pix. Line buffers are not reset.
- Window: a 3x3 register window shifts left by one column on each accept. The new right column is {LB1[c], LB0[c], in_pix}.
- Output gating: an accept with r >= 2 and c >= 2 produces an output for centre position (r-1, c-1). No other accept produces an output, giving (IMG_W-2)*(IMG_H-2) outputs per frame. There is no border output.
- Arithmetic:
  - Neighbour sum is PIX_W+3 bits unsigned.
  - Centre is scaled by a shift of 2 (mode 0) or 3 (mode 1).
  - The difference is signed, PIX_W+4 bits.
  - Result < 0 gives 0. Result > 2^PIX_W-1 gives 2^PIX_W-1. Otherwise the result is passed through.
  - Negative results must not wrap.
- Flags: out_eol is set for centre col IMG_W-2. out_eof is set for centre (IMG_H-2, IMG_W-2).
- Backpressure: the pipeline stalls as a whole. in_ready = !(out_valid && !out_ready). While stalled, no counter, buffer, window or pipeline register changes, and out_pix/out_valid/out_eol/out_eof are held stable.

## Timing
- Reset values:
  - out_pix = 0, out_valid = 0, out_eol = 0, out_eof = 0
  - in_ready = 1 after reset
  - counters = (0,0), mode register = 0, window = 0, pipeline valids = 0
- Pipeline stages: stage 1 is the window/line-buffer read on the accept edge. Stage 2 is the registered kernel sum. Stage 3 is the registered clamp to output.
- Latency: an output-producing accept on edge k gives out_valid high after edge k+2, when there are no stalls. Each stall cycle adds one cycle.
- Throughput: one pixel per cycle while in_valid and out_ready are held high.
- An output transfers on an edge with out_valid && out_ready. If no new result is arriving, out_valid drops after that edge.
- Bubbles: in_valid low inserts bubbles. Pipeline valids track them, and no output is generated for a bubble.
- Asynchronous reset mid-frame: all state clears immediately, including outputs, and any in-flight result is discarded. The next frame must begin with in_sof.

## Test plan
Use IMG_W=5, IMG_H=4, PIX_W=8 unless stated.
- Uniform frame, all pixels 100, mode 1 -> exactly 6 outputs, all 0. out_eol on outputs 3 and 6, out_eof on output 6 only.
- Background 0 with a single pixel of 10 at (2,2):
  - mode 1 -> output for centre (2,2) = 80; the other 5 outputs are 0, via negative clamp.
  - mode 0 -> 40.
- Same pattern with the pixel at 255:
  - mode 1 -> 255, since 2040 saturates.
  - mode 0 -> 255.
  - Neighbour outputs -> 0.
- Mode toggled mid-frame (0 to 1 after the 7th pixel) -> the whole frame uses mode 0. Mode 1 takes effect only from the next in_sof.
- out_ready held low for 3 cycles while out_valid = 1 -> out_pix and flags held, in_ready = 0, no input consumed. After release the full expected sequence is produced without loss or duplication, and first-output latency is 2 cycles when unstalled.
- Two cases of disruption:
  - rst_n pulsed low mid-frame -> outputs go to 0 immediately, in_ready = 1. A subsequent full frame produces the correct 6 results.
  - in_sof asserted at pixel 9 -> counters restart and the new frame's outputs are correct.
